// File: rtl/dlfloat_result_tx.sv
// DLFloat16 result streamer: buffers 16-bit results in a DEPTH-word FIFO and sends each as two bytes, high byte first.
// Latency: push into an empty FIFO with the FSM idle shows the high byte on tx_data two edges later; 1 byte/cycle at full rate.
// Backpressure: tx_data/tx_valid hold until tx_ready; res_ready (registered, "not full") drops at DEPTH, a push while low sets sticky ovf.
module dlfloat_result_tx #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic [15:0]              res_in,
    input  logic                     res_valid,
    output logic                     res_ready,
    output logic [7:0]               tx_data,
    output logic                     tx_valid,
    output logic                     tx_last,
    input  logic                     tx_ready,
    output logic                     ovf,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, HI, LO} state_t;

    state_t          state;
    logic [15:0]     mem [DEPTH];
    logic [PW-1:0]   wptr;
    logic [PW-1:0]   rptr;
    logic [7:0]      lo_byte;
    logic [15:0]     head;
    logic            push;
    logic            pop;
    logic [CW-1:0]   count_nxt;

    assign head      = mem[rptr];
    // clr wins over a same-cycle push, so gating here keeps the storage array free of reset/clear logic
    assign push      = res_valid & res_ready & ~clr;
    assign count_nxt = count + CW'(push) - CW'(pop);

    // Pop when the output register is free: idle, or the low byte is being accepted this cycle
    always_comb begin
        pop = 1'b0;
        if (!clr && count != '0) begin
            case (state)
                IDLE:    pop = 1'b1;
                LO:      pop = tx_ready;
                default: pop = 1'b0;
            endcase
        end
    end

    // Word storage; contents need no reset since count/pointers define validity
    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= res_in;
    end

    // FIFO pointers, occupancy, overflow flag and the byte-serialising FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            res_ready <= 1'b1;
            ovf       <= 1'b0;
            lo_byte   <= '0;
            tx_data   <= '0;
            tx_valid  <= 1'b0;
            tx_last   <= 1'b0;
        end else if (clr) begin
            state     <= IDLE;
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            res_ready <= 1'b1;
            ovf       <= 1'b0;
            lo_byte   <= '0;
            tx_data   <= '0;
            tx_valid  <= 1'b0;
            tx_last   <= 1'b0;
        end else begin
            if (push) wptr <= wptr + PW'(1);
            if (pop)  rptr <= rptr + PW'(1);
            count     <= count_nxt;
            // ready is registered, so it only rises the cycle after a pop from full
            res_ready <= (count_nxt != CW'(DEPTH));
            if (res_valid && !res_ready) ovf <= 1'b1;

            case (state)
                IDLE: begin
                    if (pop) begin
                        state    <= HI;
                        tx_data  <= head[15:8];
                        lo_byte  <= head[7:0];
                        tx_valid <= 1'b1;
                        tx_last  <= 1'b0;
                    end else begin
                        tx_valid <= 1'b0;
                    end
                end
                HI: begin
                    if (tx_ready) begin
                        state   <= LO;
                        tx_data <= lo_byte;
                        tx_last <= 1'b1;
                    end
                end
                LO: begin
                    if (tx_ready) begin
                        if (pop) begin
                            // next word follows immediately, no idle cycle between words
                            state   <= HI;
                            tx_data <= head[15:8];
                            lo_byte <= head[7:0];
                            tx_last <= 1'b0;
                        end else begin
                            state    <= IDLE;
                            tx_valid <= 1'b0;
                            tx_last  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    tx_valid <= 1'b0;
                    tx_last  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dlfloat_result_tx.sv
// Bench for dlfloat_result_tx: directed scenarios plus random traffic against a queue-based reference model.
// Outputs are compared every falling edge; inputs are driven on falling edges.
// Handshaked bytes are also logged for ordered-stream checks.
module tb_dlfloat_result_tx;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clr;
    logic [15:0] res_in;
    logic        res_valid;
    logic        res_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_last;
    logic        tx_ready;
    logic        ovf;
    logic [2:0]  count;

    int n_checks = 0;
    int n_pass   = 0;

    dlfloat_result_tx #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .res_in(res_in), .res_valid(res_valid), .res_ready(res_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_last(tx_last), .tx_ready(tx_ready),
        .ovf(ovf), .count(count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Reference model: words waiting in a queue, plus the word being sent and which byte is on the port
    logic [15:0] m_q[$];
    logic [15:0] m_word;
    int          m_phase;     // 0 nothing on port, 1 high byte, 2 low byte
    logic [7:0]  m_data;
    logic        m_rdy;
    logic        m_ovf;

    function automatic void m_reset();
        m_q.delete();
        m_word  = '0;
        m_phase = 0;
        m_data  = '0;
        m_rdy   = 1'b1;
        m_ovf   = 1'b0;
    endfunction

    function automatic void m_load();
        m_word  = m_q.pop_front();
        m_phase = 1;
        m_data  = m_word[15:8];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_reset();
        else if (clr) m_reset();
        else begin
            int  n;
            bit  acc;
            n   = m_q.size();
            acc = res_valid && m_rdy;
            if (res_valid && !m_rdy) m_ovf = 1'b1;
            if (m_phase == 0) begin
                if (n > 0) m_load();
            end else if (tx_ready) begin
                if (m_phase == 1) begin
                    m_phase = 2;
                    m_data  = m_word[7:0];
                end else if (n > 0) m_load();
                else m_phase = 0;
            end
            if (acc) m_q.push_back(res_in);
            m_rdy = (m_q.size() != DEPTH);
        end
    end

    // Observed byte stream (values seen on the port at each accepting edge)
    logic [7:0] obs_bytes[$];
    always @(posedge clk) begin
        if (rst_n && !clr && tx_valid && tx_ready) obs_bytes.push_back(tx_data);
    end

    // Cycle-by-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            check("tx_valid",  tx_valid,  m_phase != 0);
            check("tx_last",   tx_last,   m_phase == 2);
            check("tx_data",   tx_data,   m_data);
            check("res_ready", res_ready, m_rdy);
            check("count",     count,     m_q.size());
            check("ovf",       ovf,       m_ovf);
        end
    end

    task automatic drive(input logic v, input logic [15:0] d, input logic r);
        @(negedge clk);
        res_valid = v;
        res_in    = d;
        tx_ready  = r;
    endtask

    task automatic check_bytes(input string tag, input logic [7:0] exp[$]);
        check({tag, "_len"}, obs_bytes.size(), exp.size());
        for (int i = 0; i < exp.size() && i < obs_bytes.size(); i++)
            check(tag, obs_bytes[i], exp[i]);
    endtask

    task automatic reset_vals(input string tag);
        check({tag, "_valid"}, tx_valid,  1'b0);
        check({tag, "_last"},  tx_last,   1'b0);
        check({tag, "_data"},  tx_data,   8'h00);
        check({tag, "_ready"}, res_ready, 1'b1);
        check({tag, "_count"}, count,     3'd0);
        check({tag, "_ovf"},   ovf,       1'b0);
    endtask

    initial begin
        logic [7:0] exp[$];
        bit acc;

        rst_n = 1'b0; clr = 1'b0; res_in = '0; res_valid = 1'b0; tx_ready = 1'b0;
        #12;
        reset_vals("rst");
        @(negedge clk) rst_n = 1'b1;

        // Single word at full rate
        obs_bytes.delete();
        drive(1'b1, 16'h3E00, 1'b1);
        drive(1'b0, 16'h0000, 1'b1);
        check("single_gap", tx_valid, 1'b0);
        repeat (5) drive(1'b0, 16'h0000, 1'b1);
        exp = '{8'h3E, 8'h00};
        check_bytes("single", exp);

        // Backpressure: byte holds while sink stalls, one byte per handshake
        obs_bytes.delete();
        drive(1'b1, 16'hBF21, 1'b0);
        repeat (5) drive(1'b0, 16'h0000, 1'b0);
        check("bp_hold_v", tx_valid, 1'b1);
        check("bp_hold_d", tx_data, 8'hBF);
        for (int k = 0; k < 2; k++) begin
            drive(1'b0, 16'h0000, 1'b1);
            repeat (2) drive(1'b0, 16'h0000, 1'b0);
        end
        exp = '{8'hBF, 8'h21};
        check_bytes("bp", exp);

        // Fill to full and overflow
        obs_bytes.delete();
        for (int k = 1; k <= 5; k++) drive(1'b1, 16'(k), 1'b0);
        drive(1'b1, 16'h0006, 1'b0);
        drive(1'b0, 16'h0000, 1'b0);
        check("full_count", count, 3'd4);
        check("full_ready", res_ready, 1'b0);
        check("full_ovf", ovf, 1'b1);
        repeat (14) drive(1'b0, 16'h0000, 1'b1);
        exp = '{8'h00, 8'h01, 8'h00, 8'h02, 8'h00, 8'h03, 8'h00, 8'h04, 8'h00, 8'h05};
        check_bytes("full", exp);
        check("ovf_sticky", ovf, 1'b1);
        @(negedge clk) clr = 1'b1;
        @(negedge clk) clr = 1'b0;

        // Streaming with pointer wrap, pushing only while ready
        obs_bytes.delete();
        exp.delete();
        for (int i = 0; i < 12; i++) begin
            acc = 1'b0;
            for (int t = 0; t < 20 && !acc; t++) begin
                @(negedge clk);
                tx_ready  = 1'b1;
                res_in    = 16'h1000 + 16'(i);
                res_valid = res_ready;
                acc       = res_ready;
            end
            check("stream_acc", acc, 1'b1);
            exp.push_back(8'h10);
            exp.push_back(8'(i));
        end
        repeat (30) drive(1'b0, 16'h0000, 1'b1);
        check_bytes("stream", exp);
        check("stream_ovf", ovf, 1'b0);

        // clr while the low byte is on the port
        for (int k = 0; k < 3; k++) drive(1'b1, 16'hC000 + 16'(k), 1'b0);
        drive(1'b0, 16'h0000, 1'b1);
        drive(1'b0, 16'h0000, 1'b0);
        check("clr_pre_last", tx_last, 1'b1);
        check("clr_pre_count", count, 3'd2);
        clr = 1'b1; res_valid = 1'b1; res_in = 16'h1234; tx_ready = 1'b1;
        @(negedge clk);
        clr = 1'b0; res_valid = 1'b0;
        check("clr_valid", tx_valid, 1'b0);
        check("clr_count", count, 3'd0);
        check("clr_ovf", ovf, 1'b0);
        obs_bytes.delete();
        drive(1'b1, 16'h7FFF, 1'b1);
        repeat (6) drive(1'b0, 16'h0000, 1'b1);
        exp = '{8'h7F, 8'hFF};
        check_bytes("post_clr", exp);

        // Asynchronous reset in the middle of a word
        drive(1'b1, 16'hA5C3, 1'b0);
        repeat (3) drive(1'b0, 16'h0000, 1'b0);
        #3 rst_n = 1'b0;
        #1 reset_vals("arst");
        @(negedge clk) rst_n = 1'b1;

        // Random traffic against the model
        repeat (600) begin
            @(negedge clk);
            res_valid = ($urandom_range(0, 2) != 0);
            res_in    = 16'($urandom);
            tx_ready  = ($urandom_range(0, 3) != 0);
            clr       = ($urandom_range(0, 59) == 0);
        end
        @(negedge clk);
        res_valid = 1'b0; clr = 1'b0;
        repeat (4) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
